// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per clock
module bin_to_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      _input,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             sticky_q, sticky_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [BW-1:0]    adj;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;

    // Operand sign and magnitude; the most negative value negates to itself, which is the correct unsigned magnitude
    assign in_neg = (SIGNED != 0) && _input[WIDTH-1];
    assign in_mag = in_neg ? (~_input + {{(WIDTH-1){1'b0}}, 1'b1}) : _input;

    // Add-3 correction: each digit of 5 or more is bumped so the following doubling carries into the next digit
    always_comb begin
        adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // State and datapath registers, cleared asynchronously so a reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next state: start is only looked at in IDLE, so a start while busy is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state; result registers only change in FINISH
    always_comb begin
        mag_d    = mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d    = in_mag;
                    sign_d   = in_neg;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                end
            end
            SHIFT: begin
                acc_d    = {adj[BW-2:0], mag_q[WIDTH-1]};
                sticky_d = sticky_q | adj[BW-1];
                mag_d    = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d    = cnt_q - CW'(1);
            end
            FINISH: begin
                bcd_d  = acc_q;
                neg_d  = sign_q;
                ovf_d  = sticky_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign negative = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench over four bin_to_bcd_seq configurations
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
        longint      t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  st = 4'd0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic [31:0] in_c = 32'd0;
    logic [31:0] in_d = 32'd0;

    wire  [3:0]  dn, bs, ng, ov;
    wire  [11:0] bcd_a, bcd_b, bcd_c;
    wire  [39:0] bcd_d;
    wire  [39:0] bcd_w [4];

    exp_t   sb [4][$];
    exp_t   mon_e;
    longint cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: 8-bit unsigned, 3 digits
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), ._input(in_a), .bcd_out(bcd_a),
        .negative(ng[0]), .overflow(ov[0]), .busy(bs[0]), .done(dn[0]));
    // u1: 8-bit signed, 3 digits
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), ._input(in_b), .bcd_out(bcd_b),
        .negative(ng[1]), .overflow(ov[1]), .busy(bs[1]), .done(dn[1]));
    // u2: 32-bit signed, 3 digits (overflow-capable)
    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(3), .SIGNED(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), ._input(in_c), .bcd_out(bcd_c),
        .negative(ng[2]), .overflow(ov[2]), .busy(bs[2]), .done(dn[2]));
    // u3: 32-bit unsigned, 10 digits
    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(0)) u_d (
        .clk(clk), .rst_n(rst_n), .start(st[3]), ._input(in_d), .bcd_out(bcd_d),
        .negative(ng[3]), .overflow(ov[3]), .busy(bs[3]), .done(dn[3]));

    assign bcd_w[0] = {28'd0, bcd_a};
    assign bcd_w[1] = {28'd0, bcd_b};
    assign bcd_w[2] = {28'd0, bcd_c};
    assign bcd_w[3] = bcd_d;

    function automatic int wof(int u);
        return (u >= 2) ? 32 : 8;
    endfunction

    function automatic int dof(int u);
        return (u == 3) ? 10 : 3;
    endfunction

    function automatic bit sof(int u);
        return (u == 1) || (u == 2);
    endfunction

    // Reference: decimal arithmetic on the magnitude, independent of shift-and-add
    function automatic exp_t model(int u, logic [31:0] v);
        exp_t e;
        longint unsigned x, mag, pw, r;
        int w;
        w = wof(u);
        x = (w == 32) ? {32'd0, v} : {56'd0, v[7:0]};
        e.neg = sof(u) && x[w-1];
        mag = e.neg ? ((64'd1 << w) - x) : x;
        pw = 1;
        for (int d = 0; d < dof(u); d++) pw = pw * 10;
        e.ovf = (mag >= pw);
        r = mag % pw;
        e.bcd = '0;
        for (int k = 0; k < dof(u); k++) begin
            e.bcd[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.t0 = 0;
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive_in(int u, logic [31:0] v);
        case (u)
            0: in_a = v[7:0];
            1: in_b = v[7:0];
            2: in_c = v;
            default: in_d = v;
        endcase
    endtask

    // Start a conversion on unit u (called at a negedge); optionally push the expectation
    task automatic conv(int u, logic [31:0] v, bit expect_it);
        exp_t e;
        int k;
        k = 0;
        while (bs[u] && k < 200) begin
            @(negedge clk);
            k++;
        end
        e = model(u, v);
        st[u] = 1'b1;
        drive_in(u, v);
        @(posedge clk);
        #1;
        e.t0 = cyc;
        if (expect_it) sb[u].push_back(e);
        st[u] = 1'b0;
        drive_in(u, $urandom);
        @(negedge clk);
    endtask

    task automatic drain(int u);
        int k;
        k = 0;
        while (sb[u].size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("u%0d drain", u), sb[u].size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation and its latency
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (dn[u]) begin
                if (sb[u].size() == 0) begin
                    check($sformatf("u%0d spurious_done", u), 1, 0);
                end else begin
                    mon_e = sb[u].pop_front();
                    check($sformatf("u%0d bcd", u), bcd_w[u], mon_e.bcd);
                    check($sformatf("u%0d neg", u), ng[u], mon_e.neg);
                    check($sformatf("u%0d ovf", u), ov[u], mon_e.ovf);
                    check($sformatf("u%0d latency", u), cyc - mon_e.t0, wof(u) + 1);
                    check($sformatf("u%0d busy_at_done", u), bs[u], 0);
                end
            end
        end
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("u%0d rst bcd", u), bcd_w[u], 0);
            check($sformatf("u%0d rst flags", u), {ng[u], ov[u], bs[u], dn[u]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        conv(0, 32'd255, 1); drain(0);
        conv(0, 32'd0, 1);   drain(0);
        conv(0, 32'd137, 1); drain(0);

        conv(1, 32'h80, 1); drain(1);
        conv(1, 32'hFF, 1); drain(1);
        conv(1, 32'h7F, 1); drain(1);

        conv(2, 32'd1234, 1);       drain(2);
        conv(2, 32'd999, 1);        drain(2);
        conv(2, 32'd0, 1);          drain(2);
        conv(2, 32'd1000, 1);       drain(2);
        conv(2, 32'h8000_0000, 1);  drain(2);

        conv(3, 32'hFFFF_FFFF, 1);  drain(3);
        conv(3, 32'd1000000000, 1); drain(3);

        for (int i = 0; i < 4; i++) begin
            for (int u = 0; u < 4; u++) begin
                conv(u, $urandom, 1);
                drain(u);
            end
        end

        // start while busy is ignored: one done, original value
        conv(1, 32'd100, 1);
        repeat (3) @(negedge clk);
        st[1] = 1'b1;
        in_b = 8'd55;
        @(negedge clk);
        st[1] = 1'b0;
        drain(1);
        repeat (12) @(negedge clk);

        // start in the done cycle is accepted at the next edge
        conv(1, 32'd200, 1);
        k = 0;
        while (!dn[1] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("u1 done_seen", dn[1], 1);
        conv(1, 32'hC8, 1);
        drain(1);

        // asynchronous reset mid-conversion, leaving a nonzero previous result first
        conv(2, 32'hFFFF_FFFB, 1); drain(2);
        conv(2, 32'd777, 0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("u2 async rst bcd", bcd_w[2], 0);
        check("u2 async rst flags", {ng[2], ov[2], bs[2], dn[2]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        conv(2, 32'd42, 1); drain(2);
        conv(2, 32'hFFFF_FC18, 1); drain(2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
